// File: rtl/flick_pkg.sv
// Shared definitions for the flick push-button conditioner.
package flick_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int LONG_CYCLES_DEF     = 64;
    localparam int DB_STATE_W          = 2;

    typedef enum logic [DB_STATE_W-1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage : flick_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q1;
    logic [WIDTH-1:0] sync_q2;

    // Two back-to-back flops; the second stage is the only one consumers may use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= d;
            sync_q2 <= sync_q1;
        end
    end

    assign q = sync_q2;

endmodule : sync_2ff

// File: rtl/flick_conditioner.sv
// Debounce front end for the flick button: emits one mode-advance strobe per
// accepted press, a one-shot long-press strobe, and the debounced level.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | button released and stable
// PRESS_WAIT   | synchronized level went high, counting confirming samples
// PRESSED      | press accepted, counting hold time toward long press
// RELEASE_WAIT | level went low while pressed, counting confirming samples;
//              | hold time is parked in hold_cnt in case this is a glitch
module flick_conditioner
    import flick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flick,
    output logic                  pulse_flick,
    output logic                  long_press,
    output logic                  flick_level,
    output logic [DB_STATE_W-1:0] db_state
);

    localparam int CNT_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0] DEB_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_TC  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_nxt;
    logic             long_done;
    logic             long_done_nxt;
    logic             pulse_nxt;
    logic             long_nxt;
    logic             level_nxt;

    sync_2ff #(
        .WIDTH (1)
    ) u_sync_flick (
        .clk   (clk),
        .reset (reset),
        .d     (flick),
        .q     (s)
    );

    // State, shared counter, parked hold time and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hold_cnt    <= '0;
            long_done   <= 1'b0;
            pulse_flick <= 1'b0;
            long_press  <= 1'b0;
            flick_level <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold_cnt    <= hold_cnt_nxt;
            long_done   <= long_done_nxt;
            pulse_flick <= pulse_nxt;
            long_press  <= long_nxt;
            flick_level <= level_nxt;
        end
    end

    // Next-state and next-output decode; a change of s always beats a
    // counter reaching its threshold on the same edge.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hold_cnt_nxt  = hold_cnt;
        long_done_nxt = long_done;
        pulse_nxt     = 1'b0;
        long_nxt      = 1'b0;
        level_nxt     = flick_level;

        case (state)
            IDLE: begin
                if (s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_TC) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                end
            end

            PRESSED: begin
                if (!s) begin
                    state_nxt    = RELEASE_WAIT;
                    hold_cnt_nxt = cnt;
                    cnt_nxt      = CNT_ONE;
                end else begin
                    if (cnt != LONG_MAX) begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                    // long_done keeps a restored hold time from firing twice
                    if ((cnt == LONG_TC) && !long_done) begin
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = hold_cnt;
                end else if (cnt == DEB_TC) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    level_nxt     = 1'b0;
                    long_done_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign db_state = state;

endmodule : flick_conditioner

// File: tb/tb_flick_conditioner.sv
// Self-checking bench for flick_conditioner with a run-length reference model.
`timescale 1ns/1ps
module tb_flick_conditioner;

    localparam int DEB  = 4;
    localparam int LONG = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flick = 1'b0;
    logic       pulse_flick;
    logic       long_press;
    logic       flick_level;
    logic [1:0] db_state;

    int errors = 0;
    int checks = 0;
    int pulse_mon = 0;

    // Reference model: synchronizer delay line plus debounced level, the
    // length of the current run of disagreeing samples, and hold age.
    logic m_sq1, m_sq2, m_level, m_done;
    int   m_run, m_age;
    logic exp_pulse, exp_long;

    flick_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flick       (flick),
        .pulse_flick (pulse_flick),
        .long_press  (long_press),
        .flick_level (flick_level),
        .db_state    (db_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (pulse_flick) pulse_mon++;

    initial begin
        #2_000_000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_sq1 = 0; m_sq2 = 0; m_level = 0; m_done = 0;
        m_run = 0; m_age = 0; exp_pulse = 0; exp_long = 0;
    endtask

    task automatic model_step(input logic raw);
        logic s;
        s = m_sq2;
        m_sq2 = m_sq1;
        m_sq1 = raw;
        exp_pulse = 0;
        exp_long = 0;
        if (!m_level) begin
            if (s) begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = 1; m_run = 0; m_age = 0; exp_pulse = 1;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (s) begin
                if (m_run > 0) m_run = 0;
                else if (m_age < LONG) begin
                    m_age++;
                    if (m_age == LONG && !m_done) begin
                        exp_long = 1; m_done = 1;
                    end
                end
            end else begin
                m_run++;
                if (m_run == DEB) begin
                    m_level = 0; m_run = 0; m_done = 0;
                end
            end
        end
    endtask

    function automatic logic [1:0] exp_state();
        if (m_level) return (m_run > 0) ? 2'd3 : 2'd2;
        return (m_run > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic cycle(input logic v);
        flick = v;
        @(posedge clk);
        model_step(v);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b1;
        flick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({pulse_flick, long_press, flick_level, db_state} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {pulse_flick, long_press, flick_level, db_state});
        end
        reset = 1'b0;
        repeat (3) cycle(1'b0);
        checks++;
        if (db_state !== 2'd0) begin
            errors++; $display("FAIL reset_idle got=%0d exp=0", db_state);
        end
    endtask

    task automatic test_press();
        int pulses = 0;
        int pulse_at = -1;
        int longs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            checks++;
            if (pulse_flick !== exp_pulse) begin
                errors++; $display("FAIL press_pulse cyc=%0d got=%b exp=%b", i, pulse_flick, exp_pulse);
            end
            if (pulse_flick) begin pulses++; if (pulse_at < 0) pulse_at = i; end
            if (long_press) longs++;
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL press_count got=%0d exp=1", pulses); end
        checks++;
        if (pulse_at !== 1 + DEB) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", pulse_at, 1 + DEB); end
        checks++;
        if (flick_level !== 1'b1) begin errors++; $display("FAIL press_level got=%b exp=1", flick_level); end
        checks++;
        if (longs !== 0) begin errors++; $display("FAIL press_no_long got=%0d exp=0", longs); end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0);
        checks++;
        if (flick_level !== 1'b0) begin errors++; $display("FAIL release_level got=%b exp=0", flick_level); end
        for (int i = 0; i < 16; i++) begin
            cycle((i < 8) ? ~i[0] : 1'b0);
            checks++;
            if (db_state !== exp_state()) begin
                errors++; $display("FAIL bounce_state cyc=%0d got=%0d exp=%0d", i, db_state, exp_state());
            end
            if (pulse_flick) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL bounce_pulses got=%0d exp=0", pulses); end
        checks++;
        if (db_state !== 2'd0) begin errors++; $display("FAIL bounce_idle got=%0d exp=0", db_state); end
    endtask

    task automatic test_long();
        int pulses = 0, longs = 0, pulse_at = -1, long_at = -1;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1);
            checks++;
            if ({pulse_flick, long_press} !== {exp_pulse, exp_long}) begin
                errors++; $display("FAIL long_strobes cyc=%0d got=%b%b exp=%b%b", i, pulse_flick, long_press, exp_pulse, exp_long);
            end
            if (pulse_flick) begin pulses++; pulse_at = i; end
            if (long_press) begin longs++; long_at = i; end
        end
        checks++;
        if (pulses !== 1 || longs !== 1) begin
            errors++; $display("FAIL long_counts got=%0d/%0d exp=1/1", pulses, longs);
        end
        checks++;
        if (long_at - pulse_at !== LONG) begin
            errors++; $display("FAIL long_latency got=%0d exp=%0d", long_at - pulse_at, LONG);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0, longs = 0;
        bit saw_rw = 0;
        for (int i = 0; i < 12; i++) begin
            cycle((i < 2) ? 1'b0 : 1'b1);
            checks++;
            if (db_state !== exp_state()) begin
                errors++; $display("FAIL glitch_state cyc=%0d got=%0d exp=%0d", i, db_state, exp_state());
            end
            checks++;
            if (flick_level !== 1'b1) begin
                errors++; $display("FAIL glitch_level cyc=%0d got=%b exp=1", i, flick_level);
            end
            if (db_state == 2'd3) saw_rw = 1;
            if (pulse_flick) pulses++;
            if (long_press) longs++;
        end
        checks++;
        if (saw_rw !== 1'b1) begin errors++; $display("FAIL glitch_rw got=%b exp=1", saw_rw); end
        checks++;
        if (db_state !== 2'd2) begin errors++; $display("FAIL glitch_back got=%0d exp=2", db_state); end
        checks++;
        if (pulses + longs !== 0) begin errors++; $display("FAIL glitch_strobes got=%0d exp=0", pulses + longs); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0, pulse_at = -1;
        checks++;
        if (flick_level !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", flick_level); end
        reset = 1'b1;
        #1;
        checks++;
        if ({pulse_flick, long_press, flick_level, db_state} !== 5'b0) begin
            errors++; $display("FAIL rstmid_clear got=%b exp=00000", {pulse_flick, long_press, flick_level, db_state});
        end
        model_reset();
        #3 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1);
            checks++;
            if (pulse_flick !== exp_pulse) begin
                errors++; $display("FAIL rstmid_pulse cyc=%0d got=%b exp=%b", i, pulse_flick, exp_pulse);
            end
            if (pulse_flick) begin pulses++; if (pulse_at < 0) pulse_at = i; end
        end
        checks++;
        if (pulses !== 1 || pulse_at !== 1 + DEB) begin
            errors++; $display("FAIL rstmid_once got=%0d@%0d exp=1@%0d", pulses, pulse_at, 1 + DEB);
        end
    endtask

    task automatic test_short_pulses();
        int base;
        for (int i = 0; i < 10; i++) cycle(1'b0);
        checks++;
        if (flick_level !== 1'b0 || db_state !== 2'd0) begin
            errors++; $display("FAIL short_pre got=%b/%0d exp=0/0", flick_level, db_state);
        end
        base = pulse_mon;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) begin
                #3 flick = 1'b1; #2 flick = 1'b0; #95;
            end else begin
                #8 flick = 1'b1; #2 flick = 1'b0; #90;
            end
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (pulse_mon - base !== 0) begin
            errors++; $display("FAIL short_pulses got=%0d exp=0", pulse_mon - base);
        end
        checks++;
        if (db_state !== 2'd0) begin errors++; $display("FAIL short_idle got=%0d exp=0", db_state); end
    endtask

    task automatic test_random();
        logic v;
        int len;
        reset = 1'b1;
        flick = 1'b0;
        #2;
        model_reset();
        reset = 1'b0;
        for (int seg = 0; seg < 60; seg++) begin
            v = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(66, 90) : $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                cycle(v);
                checks++;
                if ({pulse_flick, long_press, flick_level, db_state} !==
                    {exp_pulse, exp_long, m_level, exp_state()}) begin
                    errors++;
                    $display("FAIL random seg=%0d got=%b%b%b/%0d exp=%b%b%b/%0d", seg,
                             pulse_flick, long_press, flick_level, db_state,
                             exp_pulse, exp_long, m_level, exp_state());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_long();
        test_glitch();
        test_reset_mid();
        test_short_pulses();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_flick_conditioner
